// File: rtl/sbox_share_driver.sv
// Masks bytes into three Boolean shares for a two-S-box core and unmasks its results into an output FIFO.
// Latency: LAT+2 cycles from acceptance to dout_valid_o.
// Backpressure: din_ready_o drops once in-flight plus buffered bytes reach DEPTH.
module sbox_share_driver #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic [7:0]   din_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    input  logic [105:0] rnd_i,
    output logic [7:0]   sb_in1_o,
    output logic [7:0]   sb_in2_o,
    output logic [7:0]   sb_in3_o,
    output logic [89:0]  sb_r_o,
    input  logic [7:0]   sb_out1_i,
    input  logic [7:0]   sb_out2_i,
    input  logic [7:0]   sb_out3_i,
    output logic [7:0]   dout_o,
    output logic         dout_valid_o,
    input  logic         dout_ready_i
);
    localparam int SW = $clog2(LAT + DEPTH + 2);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    sb_in1_q, sb_in1_d;
    logic [7:0]    sb_in2_q, sb_in2_d;
    logic [7:0]    sb_in3_q, sb_in3_d;
    logic [89:0]   sb_r_q, sb_r_d;
    logic [LAT:0]  tag_q, tag_d;
    logic [SW-1:0] inflight_q, inflight_d;
    logic [SW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          din_ready_q, din_ready_d;
    logic          accept;
    logic          wr_en;
    logic          pop;
    logic [7:0]    mask2;
    logic [7:0]    mask3;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mask2      = rnd_i[97:90];
        mask3      = rnd_i[105:98];
        accept     = din_valid_i & din_ready_q;
        wr_en      = tag_q[LAT];
        pop        = (count_q != '0) & dout_ready_i;

        // Idle cycles still feed a fresh sharing of zero so the core never sees stale data.
        sb_in2_d   = mask2;
        sb_in3_d   = mask3;
        sb_in1_d   = (accept ? din_i : 8'h00) ^ mask2 ^ mask3;
        sb_r_d     = rnd_i[89:0];

        tag_d      = {tag_q[LAT-1:0], accept};
        inflight_d = inflight_q + SW'(accept) - SW'(wr_en);
        count_d    = count_q + SW'(wr_en) - SW'(pop);

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = sb_out1_i ^ sb_out2_i ^ sb_out3_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // Ready is registered from next-state counters: no path from din_valid_i/dout_ready_i to din_ready_o.
        din_ready_d = (inflight_d + count_d) < SW'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sb_in1_q    <= '0;
            sb_in2_q    <= '0;
            sb_in3_q    <= '0;
            sb_r_q      <= '0;
            tag_q       <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            din_ready_q <= 1'b0;
        end else begin
            sb_in1_q    <= sb_in1_d;
            sb_in2_q    <= sb_in2_d;
            sb_in3_q    <= sb_in3_d;
            sb_r_q      <= sb_r_d;
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            din_ready_q <= din_ready_d;
        end
    end

    assign sb_in1_o     = sb_in1_q;
    assign sb_in2_o     = sb_in2_q;
    assign sb_in3_o     = sb_in3_q;
    assign sb_r_o       = sb_r_q;
    assign din_ready_o  = din_ready_q;
    assign dout_valid_o = (count_q != '0);
    assign dout_o       = mem_q[rd_ptr_q];
endmodule

// File: doc/sbox_share_driver.md
SBOX_SHARE_DRIVER -- requirements
Module: sbox_share_driver

Interface
REQ-001 Parameter LAT, default 3: register-stage latency of the attached masked two-S-box core, from share input to share output.
REQ-002 Parameter DEPTH, default 4: result FIFO depth, and the limit on in-flight plus buffered bytes.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 din_i  input  8  unmasked byte to substitute.
REQ-006 din_valid_i  input  1  din_i valid.
REQ-007 din_ready_o  output  1  block can accept a byte this cycle.
REQ-008 rnd_i  input  106  fresh randomness, new every cycle.
REQ-009 sb_in1_o, sb_in2_o, sb_in3_o  output  8 each  Boolean shares to the core; bits [3:0] feed S-box 0, bits [7:4] feed S-box 1.
REQ-010 sb_r_o  output  90  core randomness; [44:0] for S-box 0, [89:45] for S-box 1.
REQ-011 sb_out1_i, sb_out2_i, sb_out3_i  input  8 each  output shares returned by the core.
REQ-012 dout_o  output  8  unmasked S-box result.
REQ-013 dout_valid_i/dout_valid_o: dout_valid_o  output  1  dout_o valid.
REQ-014 dout_ready_i  input  1  downstream accepts dout_o.

Function
REQ-015 A byte SHALL be accepted in a cycle only when din_valid_i and din_ready_o are both 1 at the edge.
REQ-016 On acceptance, the block SHALL register the following values, visible on its outputs the next cycle:
- sb_in2_o = rnd_i[97:90]
- sb_in3_o = rnd_i[105:98]
- sb_in1_o = din_i ^ rnd_i[97:90] ^ rnd_i[105:98]
REQ-017 When no byte is accepted, the block SHALL register a fresh sharing of 0x00 using the same slices: sb_in1_o = rnd_i[97:90] ^ rnd_i[105:98]. The core SHALL never see stale or unmasked data.
REQ-018 sb_r_o SHALL be registered from rnd_i[89:0] every cycle, whether or not a byte is accepted.
REQ-019 Latency tracking SHALL use a LAT+1-deep valid shift register. A tag entered at acceptance marks the cycle in which the core output shares belong to that byte, LAT cycles after the shares appear.
REQ-020 In that cycle, sb_out1_i ^ sb_out2_i ^ sb_out3_i SHALL be written to the FIFO. Untagged cycles SHALL write nothing.
REQ-021 Total latency SHALL be LAT+2 cycles: a byte accepted at edge t gives dout_valid_o=1 in the cycle after edge t+LAT+1 at the earliest (5 cycles for LAT=3).
REQ-022 The FIFO SHALL be first-word-fall-through:
- dout_o is the head entry while dout_valid_o=1.
- The head is popped when dout_valid_o and dout_ready_i are both 1.
REQ-023 Counter inflight (0..LAT+1) SHALL count accepted bytes not yet written to the FIFO. Counter count (0..DEPTH) SHALL count FIFO entries.
REQ-024 din_ready_o SHALL equal (inflight + count < DEPTH), computed from registered state only, with no combinational path from din_valid_i or dout_ready_i.
REQ-025 Simultaneous accept, FIFO write and pop in one cycle SHALL update both counters correctly, with no loss or duplication.
REQ-026 The FIFO SHALL never overflow. A write when count == DEPTH is unreachable and SHALL be flagged by a bench assertion.
REQ-027 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-028 Output order SHALL equal acceptance order.

Reset
REQ-029 While rst_i=1 at an edge, the following SHALL be cleared to 0:
- sb_in1_o, sb_in2_o, sb_in3_o, sb_r_o
- the valid shift register, inflight, count, and FIFO pointers
- dout_valid_o and din_ready_o
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and buffered bytes, with no later dout_valid_o for them.
REQ-031 din_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Verification
REQ-032 The bench SHALL attach a behavioural masked-core model of latency LAT that returns shares XOR-ing to the PRESENT S-box of each nibble. PRESENT table for inputs 0..F: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
REQ-033 Single byte: accept 0x21 at cycle 0, dout_ready_i=1 -> dout_o=0x65 with dout_valid_o=1 at cycle 5 (LAT=3), for one cycle only.
REQ-034 Streaming: bytes 0x00, 0xFF, 0x5A in consecutive cycles with dout_ready_i=1 -> outputs 0xCC, 0x22, 0x0F in order, on consecutive cycles.
REQ-035 Backpressure: dout_ready_i=0 with din_valid_i held at 1 -> exactly 4 bytes accepted, then din_ready_o=0. Raising dout_ready_i -> all 4 results delivered in order, and din_ready_o returns to 1 the cycle after the first pop.
REQ-036 Masking check: with din_i=0xA5 and rnd_i[105:90]=0x3C7E, the next cycle shows sb_in2_o=0x7E, sb_in3_o=0x3C, sb_in1_o=0xE7. With no byte accepted, sb_in1_o^sb_in2_o^sb_in3_o=0x00.
REQ-037 Reset mid-flight: accept 2 bytes, assert rst_i for 1 cycle at cycle 2 -> dout_valid_o stays 0 for the next 10 cycles, and din_ready_o=1 after release.
